// File: rtl/unit_d.sv
// unit_d: 32-bit multi-cycle restoring divider (unsigned / signed) with a
// start/done handshake and fixed 34-cycle latency; divide-by-zero is a one-cycle fast path.
module unit_d (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  f,
   output logic [31:0] q,
   output logic [31:0] r,
   output logic        busy,
   output logic        done,
   output logic        dz,
   output logic        O,
   output logic        Z
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [1:0]  f_q, f_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [32:0] rem_q, rem_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        sgnq_q, sgnq_d;
   logic        sgnr_q, sgnr_d;
   logic [31:0] q_q, q_d;
   logic [31:0] r_q, r_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dz_q, dz_d;
   logic        o_q, o_d;
   logic        z_q, z_d;

   logic        sgn_mode_s;
   logic [32:0] rem_sh_s;
   logic [32:0] trial_s;
   logic        trial_ok_s;
   logic [31:0] qfix_s;
   logic [31:0] rfix_s;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      neg32 = ~x + 32'd1;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] x, input logic en);
      abs32 = (en && x[31]) ? neg32(x) : x;
   endfunction

   // Datapath helpers: one restoring step and the final sign fix-up.
   always_comb begin
      sgn_mode_s = (f == 2'b01);
      rem_sh_s   = {rem_q[31:0], dvd_q[31]};
      trial_s    = rem_sh_s - {1'b0, dvs_q};
      // A set rem_q[32] would make the shifted value exceed any divisor.
      trial_ok_s = rem_q[32] | ~trial_s[32];
      qfix_s     = sgnq_q ? neg32(dvd_q) : dvd_q;
      rfix_s     = sgnr_q ? neg32(rem_q[31:0]) : rem_q[31:0];
   end

   // Next-state and register-update logic for the controller and datapath.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      f_d     = f_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      sgnq_d  = sgnq_q;
      sgnr_d  = sgnr_q;
      q_d     = q_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      o_d     = o_q;
      z_d     = z_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               f_d   = f;
               cnt_d = 6'd0;
               rem_d = 33'd0;
               if (b == 32'd0) begin
                  dvd_d   = 32'd0;
                  dvs_d   = 32'd0;
                  sgnq_d  = 1'b0;
                  sgnr_d  = 1'b0;
                  q_d     = 32'hFFFF_FFFF;
                  r_d     = a;
                  dz_d    = 1'b1;
                  o_d     = 1'b0;
                  z_d     = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  dvd_d   = abs32(a, sgn_mode_s);
                  dvs_d   = abs32(b, sgn_mode_s);
                  sgnq_d  = sgn_mode_s & (a[31] ^ b[31]);
                  sgnr_d  = sgn_mode_s & a[31];
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (trial_ok_s) begin
               rem_d = trial_s;
               dvd_d = {dvd_q[30:0], 1'b1};
            end else begin
               rem_d = rem_sh_s;
               dvd_d = {dvd_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = FIX;
            end else begin
               state_d = RUN;
            end
         end
         FIX: begin
            q_d     = qfix_s;
            r_d     = rfix_s;
            z_d     = (qfix_s == 32'd0);
            o_d     = (f_q == 2'b01) && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         f_q     <= 2'd0;
         dvd_q   <= 32'd0;
         dvs_q   <= 32'd0;
         rem_q   <= 33'd0;
         cnt_q   <= 6'd0;
         sgnq_q  <= 1'b0;
         sgnr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         sgnq_q  <= sgnq_d;
         sgnr_q  <= sgnr_d;
      end
   end

   // Result and status output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= 32'd0;
         r_q    <= 32'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         o_q    <= 1'b0;
         z_q    <= 1'b0;
      end else begin
         q_q    <= q_d;
         r_q    <= r_d;
         busy_q <= busy_d;
         done_q <= done_d;
         dz_q   <= dz_d;
         o_q    <= o_d;
         z_q    <= z_d;
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;
   assign O    = o_q;
   assign Z    = z_q;

endmodule
